// File: rtl/riscv_mem_pkg.sv
// Shared memory-port types: owner tag, arbiter FSM states and request bundle.
// Imported by the memory-side arbiter of the datapath.
package riscv_mem_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } mem_owner_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } mem_arb_state_t;

    typedef struct packed {
        logic [XLEN-1:0]   addr;
        logic [XLEN/8-1:0] wmask;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters.
// Ports: clock/reset; if_req*/if_rsp* fetch side; d_req*/d_rsp* data side;
// mem_req*/mem_rsp* memory side. One transaction in flight at a time.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [XLEN-1:0]   if_req_addr,
    output logic              if_rsp_valid,
    output logic [XLEN-1:0]   if_rsp_rdata,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [XLEN-1:0]   d_req_addr,
    input  logic [XLEN/8-1:0] d_req_wmask,
    input  logic [XLEN-1:0]   d_req_wdata,
    output logic              d_rsp_valid,
    output logic [XLEN-1:0]   d_rsp_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [XLEN-1:0]   mem_req_addr,
    output logic [XLEN/8-1:0] mem_req_wmask,
    output logic [XLEN-1:0]   mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata
);

    import riscv_mem_pkg::*;

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    mem_arb_state_t r_state;
    mem_arb_state_t w_next_state;
    mem_owner_t     r_owner;
    mem_req_t       r_req;
    logic [CW-1:0]  r_starve;

    logic w_starved;
    logic w_grant_fetch;
    logic w_grant_data;
    logic w_rsp_hit;

    assign w_starved = (r_starve == LIMIT);

    // Grants are suppressed during reset so no handshake is reported
    // for a request that the reset would discard.
    always_comb begin
        w_next_state  = r_state;
        w_grant_fetch = 1'b0;
        w_grant_data  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!reset) begin
                    if (if_req_valid && (!d_req_valid || w_starved)) begin
                        w_grant_fetch = 1'b1;
                    end else if (d_req_valid) begin
                        w_grant_data = 1'b1;
                    end
                    if (if_req_valid || d_req_valid) begin
                        w_next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (mem_req_ready) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= OWN_DATA;
            r_req    <= '0;
            r_starve <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_grant_fetch) begin
                r_owner      <= OWN_FETCH;
                r_req.addr   <= if_req_addr;
                r_req.wmask  <= '0;
                r_req.wdata  <= '0;
                r_starve     <= '0;
            end else if (w_grant_data) begin
                r_owner      <= OWN_DATA;
                r_req.addr   <= d_req_addr;
                r_req.wmask  <= d_req_wmask;
                r_req.wdata  <= d_req_wdata;
                // Fetch lost this arbitration: count it, saturating.
                if (if_req_valid && !w_starved) begin
                    r_starve <= r_starve + 1'b1;
                end
            end
        end
    end

    assign if_req_ready  = w_grant_fetch;
    assign d_req_ready   = w_grant_data;

    assign mem_req_valid = (r_state == ISSUE);
    assign mem_req_addr  = r_req.addr;
    assign mem_req_wmask = r_req.wmask;
    assign mem_req_wdata = r_req.wdata;

    // Response is a combinational pass-through to the owning requester.
    assign w_rsp_hit     = (r_state == WAIT) && mem_rsp_valid && !reset;
    assign if_rsp_valid  = w_rsp_hit && (r_owner == OWN_FETCH);
    assign d_rsp_valid   = w_rsp_hit && (r_owner == OWN_DATA);
    assign if_rsp_rdata  = if_rsp_valid ? mem_rsp_rdata : '0;
    assign d_rsp_rdata   = d_rsp_valid ? mem_rsp_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, backpressure,
// contention/starvation, reset in WAIT and idle behaviour.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_rdata;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic [3:0]  d_req_wmask;
    logic [31:0] d_req_wdata;
    logic        d_rsp_valid;
    logic [31:0] d_rsp_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [3:0]  mem_req_wmask;
    logic [31:0] mem_req_wdata;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    int n_cmp;
    int n_err;

    mem_port_arbiter #(
        .XLEN        (32),
        .STARVE_LIMIT(4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .if_req_valid (if_req_valid),
        .if_req_ready (if_req_ready),
        .if_req_addr  (if_req_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rsp_rdata (if_rsp_rdata),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_wmask  (d_req_wmask),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .d_rsp_rdata  (d_rsp_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_req_wmask(mem_req_wmask),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".mem_req_valid"}, 32'(mem_req_valid), 32'd0);
        chk({tag, ".if_req_ready"}, 32'(if_req_ready), 32'd0);
        chk({tag, ".d_req_ready"}, 32'(d_req_ready), 32'd0);
        chk({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
        chk({tag, ".d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
        chk({tag, ".if_rsp_rdata"}, if_rsp_rdata, 32'd0);
        chk({tag, ".d_rsp_rdata"}, d_rsp_rdata, 32'd0);
    endtask

    // One full arbitration with both requesters valid (fetch 0x1000,
    // data read 0x2000); exp_f says whether fetch must win.
    task automatic arb(input string tag, input logic exp_f);
        settle();
        chk({tag, ".if_ready"}, 32'(if_req_ready), 32'(exp_f));
        chk({tag, ".d_ready"}, 32'(d_req_ready), 32'(!exp_f));
        tick();
        mem_req_ready = 1'b1;
        settle();
        chk({tag, ".addr"}, mem_req_addr,
            exp_f ? 32'h0000_1000 : 32'h0000_2000);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0000_00A5;
        settle();
        chk({tag, ".if_rsp"}, 32'(if_rsp_valid), 32'(exp_f));
        chk({tag, ".d_rsp"}, 32'(d_rsp_valid), 32'(!exp_f));
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        if_req_valid = 1'b0;
        if_req_addr = '0;
        d_req_valid = 1'b0;
        d_req_addr = '0;
        d_req_wmask = '0;
        d_req_wdata = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();
        chk_quiet("reset");
        chk("reset.addr", mem_req_addr, 32'd0);
        chk("reset.wmask", 32'(mem_req_wmask), 32'd0);

        // Single fetch
        if_req_valid = 1'b1;
        if_req_addr = 32'h0000_0010;
        settle();
        chk("fetch.if_ready", 32'(if_req_ready), 32'd1);
        chk("fetch.d_ready", 32'(d_req_ready), 32'd0);
        tick();
        if_req_valid = 1'b0;
        if_req_addr = 32'hFFFF_FFFF;
        mem_req_ready = 1'b1;
        settle();
        chk("fetch.mvalid", 32'(mem_req_valid), 32'd1);
        chk("fetch.maddr", mem_req_addr, 32'h0000_0010);
        chk("fetch.mwmask", 32'(mem_req_wmask), 32'd0);
        chk("fetch.mwdata", mem_req_wdata, 32'd0);
        chk("fetch.d_rsp_t1", 32'(d_rsp_valid), 32'd0);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0000_0013;
        settle();
        chk("fetch.mvalid_wait", 32'(mem_req_valid), 32'd0);
        chk("fetch.if_rsp", 32'(if_rsp_valid), 32'd1);
        chk("fetch.if_rdata", if_rsp_rdata, 32'h0000_0013);
        chk("fetch.d_rsp", 32'(d_rsp_valid), 32'd0);
        chk("fetch.d_rdata", d_rsp_rdata, 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk_quiet("fetch.after");

        // Store
        d_req_valid = 1'b1;
        d_req_addr = 32'h0000_0100;
        d_req_wmask = 4'b0011;
        d_req_wdata = 32'hDEAD_BEEF;
        settle();
        chk("store.d_ready", 32'(d_req_ready), 32'd1);
        chk("store.if_ready", 32'(if_req_ready), 32'd0);
        tick();
        d_req_valid = 1'b0;
        d_req_wdata = 32'h1234_5678;
        mem_req_ready = 1'b1;
        settle();
        chk("store.maddr", mem_req_addr, 32'h0000_0100);
        chk("store.mwmask", 32'(mem_req_wmask), 32'h3);
        chk("store.mwdata", mem_req_wdata, 32'hDEAD_BEEF);
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h5555_AAAA;
        settle();
        chk("store.d_rsp", 32'(d_rsp_valid), 32'd1);
        chk("store.if_rsp", 32'(if_rsp_valid), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        settle();
        chk("store.pulse", 32'(d_rsp_valid), 32'd0);

        // Memory backpressure: fetch arrives while data read is in ISSUE
        d_req_valid = 1'b1;
        d_req_addr = 32'h0000_0200;
        d_req_wmask = 4'b0000;
        settle();
        chk("bp.d_ready", 32'(d_req_ready), 32'd1);
        tick();
        d_req_valid = 1'b0;
        d_req_addr = 32'h0000_0BAD;
        if_req_valid = 1'b1;
        if_req_addr = 32'h0000_0300;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp.mvalid", 32'(mem_req_valid), 32'd1);
            chk("bp.maddr", mem_req_addr, 32'h0000_0200);
            chk("bp.if_ready", 32'(if_req_ready), 32'd0);
            chk("bp.d_ready_hold", 32'(d_req_ready), 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        settle();
        chk("bp.maddr_acc", mem_req_addr, 32'h0000_0200);
        tick();
        mem_req_ready = 1'b0;
        if_req_valid = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hCAFE_0001;
        settle();
        chk("bp.d_rsp", 32'(d_rsp_valid), 32'd1);
        chk("bp.d_rdata", d_rsp_rdata, 32'hCAFE_0001);
        chk("bp.if_rsp", 32'(if_rsp_valid), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;

        // Contention: D,D,D,D,F,D,D,D,D,F
        if_req_valid = 1'b1;
        if_req_addr = 32'h0000_1000;
        d_req_valid = 1'b1;
        d_req_addr = 32'h0000_2000;
        d_req_wmask = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            arb($sformatf("cont%0d", i), (i == 4) || (i == 9));
        end
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;

        // Reset while in WAIT
        if_req_valid = 1'b1;
        if_req_addr = 32'h0000_0040;
        tick();
        if_req_valid = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk_quiet("rst_wait");
        chk("rst_wait.addr", mem_req_addr, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h7777_7777;
        settle();
        chk("rst_wait.stray_if", 32'(if_rsp_valid), 32'd0);
        chk("rst_wait.stray_d", 32'(d_rsp_valid), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;

        // Build starve count of 2, idle 10 cycles, then fetch wins
        // on the third contended arbitration.
        if_req_valid = 1'b1;
        if_req_addr = 32'h0000_1000;
        d_req_valid = 1'b1;
        d_req_addr = 32'h0000_2000;
        arb("pre0", 1'b0);
        arb("pre1", 1'b0);
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk_quiet($sformatf("idle%0d", i));
            tick();
        end
        if_req_valid = 1'b1;
        d_req_valid = 1'b1;
        arb("post0", 1'b0);
        arb("post1", 1'b0);
        arb("post2", 1'b1);
        if_req_valid = 1'b0;
        d_req_valid = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
